// File: rtl/pwm_generator_if.sv
// pwm_generator_if: command/status bundle between the motor mixer and one PWM transmitter.
//   enable           : master -> slave, run frames continuously while high
//   pulse_length_us  : master -> slave, commanded high time in us (sampled at frame start)
//   pwm              : slave -> master, registered PWM waveform
//   frame_start      : slave -> master, one-cycle strobe on the first high cycle of a frame
//   active_length_us : slave -> master, clamped high time of the frame being emitted
interface pwm_generator_if;
    logic        enable;
    logic [15:0] pulse_length_us;
    logic        pwm;
    logic        frame_start;
    logic [15:0] active_length_us;

    modport master (
        output enable,
        output pulse_length_us,
        input  pwm,
        input  frame_start,
        input  active_length_us
    );

    modport slave (
        input  enable,
        input  pulse_length_us,
        output pwm,
        output frame_start,
        output active_length_us
    );
endinterface

// File: rtl/pwm_generator.sv
// pwm_generator: servo/ESC PWM transmitter on the 1 us clock.
//   us_clk : 1 us period clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : pwm_generator_if.slave (enable, pulse_length_us in; pwm, frame_start,
//            active_length_us out, all outputs straight from flops)
// High time is clamped to MIN..MAX and latched only at frame start so pulses are glitch-free.
module pwm_generator #(
    parameter logic [15:0] PERIOD_US                = 16'd20000,
    parameter logic [15:0] DEFAULT_PWM_TIME_HIGH_US = 16'd1500,
    parameter logic [15:0] MIN_PWM_TIME_HIGH_US     = 16'd1000,
    parameter logic [15:0] MAX_PWM_TIME_HIGH_US     = 16'd2000
) (
    input  logic           us_clk,
    input  logic           reset,
    pwm_generator_if.slave bus
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_counter;
    logic [CNT_W-1:0] w_counter_nxt;
    logic             r_pwm;
    logic             w_pwm_nxt;
    logic             r_frame_start;
    logic             w_frame_start_nxt;
    logic [CNT_W-1:0] r_active_len;
    logic [CNT_W-1:0] w_active_len_nxt;
    logic [CNT_W-1:0] w_counter_inc;

    // Unsigned clamp into the legal high-time window.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] v);
        if (v < MIN_PWM_TIME_HIGH_US) begin
            return MIN_PWM_TIME_HIGH_US;
        end else if (v > MAX_PWM_TIME_HIGH_US) begin
            return MAX_PWM_TIME_HIGH_US;
        end else begin
            return v;
        end
    endfunction

    assign w_counter_inc = r_counter + CNT_W'(1);

    // State and output registers.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_counter     <= '0;
            r_pwm         <= 1'b0;
            r_frame_start <= 1'b0;
            r_active_len  <= DEFAULT_PWM_TIME_HIGH_US;
        end else begin
            r_state       <= w_state_nxt;
            r_counter     <= w_counter_nxt;
            r_pwm         <= w_pwm_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_active_len  <= w_active_len_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_counter_nxt     = r_counter;
        w_pwm_nxt         = r_pwm;
        w_frame_start_nxt = 1'b0;
        w_active_len_nxt  = r_active_len;

        case (r_state)
            S_IDLE: begin
                w_counter_nxt = '0;
                w_pwm_nxt     = 1'b0;
                if (bus.enable) begin
                    w_state_nxt       = S_HIGH;
                    w_pwm_nxt         = 1'b1;
                    w_frame_start_nxt = 1'b1;
                    w_active_len_nxt  = clamp_len(bus.pulse_length_us);
                end
            end
            S_HIGH: begin
                // Counter keeps running through the whole frame so LOW ends at PERIOD_US-1.
                w_counter_nxt = w_counter_inc;
                if (r_counter == r_active_len - CNT_W'(1)) begin
                    w_state_nxt = S_LOW;
                    w_pwm_nxt   = 1'b0;
                end
            end
            S_LOW: begin
                w_counter_nxt = w_counter_inc;
                if (r_counter == PERIOD_US - CNT_W'(1)) begin
                    if (bus.enable) begin
                        // Back-to-back frame on the same edge.
                        w_state_nxt       = S_HIGH;
                        w_counter_nxt     = '0;
                        w_pwm_nxt         = 1'b1;
                        w_frame_start_nxt = 1'b1;
                        w_active_len_nxt  = clamp_len(bus.pulse_length_us);
                    end else begin
                        w_state_nxt   = S_IDLE;
                        w_counter_nxt = '0;
                        w_pwm_nxt     = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt       = S_IDLE;
                w_counter_nxt     = '0;
                w_pwm_nxt         = 1'b0;
                w_frame_start_nxt = 1'b0;
                w_active_len_nxt  = DEFAULT_PWM_TIME_HIGH_US;
            end
        endcase
    end

    assign bus.pwm              = r_pwm;
    assign bus.frame_start      = r_frame_start;
    assign bus.active_length_us = r_active_len;

endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: scoreboard bench for pwm_generator. The driver pushes the clamped
// high time it expects for each commanded frame; the monitor pops on every pwm falling
// edge and compares measured high time and active_length_us, and checks frame period.
module tb_pwm_generator;
    localparam logic [15:0] PERIOD = 16'd3000;
    localparam logic [15:0] DEF_HI = 16'd1500;
    localparam logic [15:0] MIN_HI = 16'd1000;
    localparam logic [15:0] MAX_HI = 16'd2000;

    logic us_clk;
    logic reset;

    pwm_generator_if bus ();

    pwm_generator #(
        .PERIOD_US                (PERIOD),
        .DEFAULT_PWM_TIME_HIGH_US (DEF_HI),
        .MIN_PWM_TIME_HIGH_US     (MIN_HI),
        .MAX_PWM_TIME_HIGH_US     (MAX_HI)
    ) dut (
        .us_clk (us_clk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    initial us_clk = 1'b0;
    always #5 us_clk = ~us_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          sb[$];
    int          cyc = 0;
    int          last_fs = 0;
    bit          last_ok = 1'b0;
    bit          skip_period = 1'b0;
    int          hi_cnt = 0;
    logic        prev_pwm = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp_ref(input int v);
        if (v < int'(MIN_HI)) return int'(MIN_HI);
        if (v > int'(MAX_HI)) return int'(MAX_HI);
        return v;
    endfunction

    // Command a new high time for the next frame start and record the expectation.
    task automatic command(input int v);
        bus.pulse_length_us = 16'(v);
        sb.push_back(clamp_ref(v));
    endtask

    task automatic wait_fs(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge us_clk);
            n++;
        end while (!bus.frame_start && n < budget);
        check_eq("fs_timeout", 32'(bus.frame_start), 32'd1);
    endtask

    // Monitor: measure pulses and frame spacing away from the active edge.
    always @(negedge us_clk) begin
        int exp_hi;
        cyc++;
        if (reset) begin
            hi_cnt   = 0;
            prev_pwm = 1'b0;
            last_ok  = 1'b0;
            sb.delete();
        end else begin
            if (bus.pwm) hi_cnt++;
            if (bus.frame_start) begin
                check_eq("fs_on_rise", {30'd0, prev_pwm, bus.pwm}, 32'd1);
                if (last_ok && !skip_period)
                    check_eq("period", 32'(cyc - last_fs), 32'(PERIOD));
                skip_period = 1'b0;
                last_fs     = cyc;
                last_ok     = 1'b1;
            end
            if (prev_pwm && !bus.pwm) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    exp_hi = sb.pop_front();
                    check_eq("high_time", 32'(hi_cnt), 32'(exp_hi));
                    check_eq("active_len", 32'(bus.active_length_us), 32'(exp_hi));
                end
                hi_cnt = 0;
            end
            prev_pwm = bus.pwm;
        end
    end

    initial begin
        int fs_seen;
        int vals[5];
        vals[0] = 1500; vals[1] = 0; vals[2] = 65535; vals[3] = 1000; vals[4] = 2000;

        reset               = 1'b1;
        bus.enable          = 1'b0;
        bus.pulse_length_us = 16'd1500;
        repeat (3) @(negedge us_clk);
        check_eq("rst_pwm", 32'(bus.pwm), 32'd0);
        check_eq("rst_fs", 32'(bus.frame_start), 32'd0);
        check_eq("rst_active", 32'(bus.active_length_us), 32'(DEF_HI));

        reset = 1'b0;
        repeat (2) @(negedge us_clk);
        check_eq("idle_pwm", 32'(bus.pwm), 32'd0);

        // Startup latency: enable seen at the next edge gives pwm and frame_start.
        command(1500);
        bus.enable = 1'b1;
        @(posedge us_clk);
        #1;
        check_eq("start_pwm", 32'(bus.pwm), 32'd1);
        check_eq("start_fs", 32'(bus.frame_start), 32'd1);
        @(negedge us_clk);

        // Clamp boundaries, back to back.
        foreach (vals[i]) begin
            command(vals[i]);
            wait_fs(int'(PERIOD) + 10);
        end

        // Command change mid-pulse is deferred to the next frame.
        command(1200);
        wait_fs(int'(PERIOD) + 10);
        repeat (600) @(negedge us_clk);
        command(1800);
        check_eq("mid_active", 32'(bus.active_length_us), 32'd1200);
        wait_fs(int'(PERIOD) + 10);
        check_eq("next_active", 32'(bus.active_length_us), 32'd1800);

        // Disable 100 cycles into a pulse: pulse and frame finish, then IDLE.
        command(1500);
        wait_fs(int'(PERIOD) + 10);
        repeat (100) @(negedge us_clk);
        bus.enable = 1'b0;
        fs_seen = 0;
        repeat (int'(PERIOD) + 200) begin
            @(negedge us_clk);
            if (bus.frame_start) fs_seen++;
        end
        check_eq("idle_no_fs", 32'(fs_seen), 32'd0);
        check_eq("idle_pwm2", 32'(bus.pwm), 32'd0);
        check_eq("idle_hold", 32'(bus.active_length_us), 32'd1500);

        // Re-enable from IDLE.
        skip_period = 1'b1;
        command(1600);
        bus.enable = 1'b1;
        @(posedge us_clk);
        #1;
        check_eq("reen_pwm", 32'(bus.pwm), 32'd1);
        @(negedge us_clk);

        // Reset 700 cycles into a pulse drops pwm without a clock edge.
        command(1700);
        wait_fs(int'(PERIOD) + 10);
        repeat (700) @(negedge us_clk);
        check_eq("pre_rst_pwm", 32'(bus.pwm), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_pwm", 32'(bus.pwm), 32'd0);
        check_eq("async_fs", 32'(bus.frame_start), 32'd0);
        check_eq("async_active", 32'(bus.active_length_us), 32'(DEF_HI));
        repeat (2) @(negedge us_clk);
        #2 reset = 1'b0;
        command(1400);
        wait_fs(10);
        command(1400);
        wait_fs(int'(PERIOD) + 10);
        repeat (1500) @(negedge us_clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Generates a servo/ESC-style PWM waveform whose high time in microseconds is set by a 16-bit command word, running on the 1 µs clock. It is the transmit counterpart of the PWM pulse-width reader and sits between the motor-mixing logic and the ESC output pins, one instance per motor. High time is clamped to the `MIN_PWM_TIME_HIGH_US`..`MAX_PWM_TIME_HIGH_US` window from `common_defines.v` and is only updated at frame boundaries, so every emitted pulse is glitch-free.

## Interface
- PERIOD_US, 16'd20000, frame length in us_clk cycles; legal range `MAX_PWM_TIME_HIGH_US`+1 .. 65535.
- DEFAULT_PWM_TIME_HIGH_US, 16'd1500, value of active_length_us after reset.
- us_clk  in  1  1 µs period clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = generate frames continuously; 0 = stop at end of current frame.
- pulse_length_us  in  16  commanded high time in µs; sampled only at frame start.
- pwm  out  1  registered PWM output.
- frame_start  out  1  one-cycle strobe, high during the first high cycle of each frame.
- active_length_us  out  16  clamped high time of the frame currently being emitted.

## Operation
- Reset (asynchronous): state IDLE, pwm 0, frame_start 0, counter 0, active_length_us = DEFAULT_PWM_TIME_HIGH_US. Reset asserted mid-pulse drops pwm to 0 immediately, without waiting for a clock edge.
- FSM states: IDLE, HIGH, LOW. Encoding is 2 bits. Unreachable encodings go to IDLE with the same values as reset.
- Clamp function: the input is compared as unsigned. If the input is below `MIN_PWM_TIME_HIGH_US`, the result is MIN. If it is above `MAX_PWM_TIME_HIGH_US`, the result is MAX. Otherwise the input passes through unchanged. An input of 0 therefore yields MIN.
- Frame start, taken from IDLE with enable=1 or from LOW at the frame end with enable=1:
  - state <= HIGH, pwm <= 1, frame_start <= 1, counter <= 0.
  - active_length_us <= clamp(pulse_length_us).
- HIGH:
  - counter increments each cycle and frame_start <= 0.
  - When counter == active_length_us-1: state <= LOW, pwm <= 0.
  - pwm is therefore high for exactly active_length_us cycles.
- LOW:
  - counter increments each cycle.
  - When counter == PERIOD_US-1, the frame ends. If enable=1, a new frame starts on that same edge (back-to-back, no gap). If enable=0: state <= IDLE, counter <= 0, pwm stays 0.
- IDLE: pwm 0, counter held at 0, active_length_us holds its last value.
- Changes on pulse_length_us during a frame are ignored until the next frame start.
- Deasserting enable mid-frame never truncates a pulse or a frame.
- Counter is 16 bits and never wraps, because PERIOD_US ≤ 65535.

## Timing
- Startup latency: enable sampled high in IDLE at edge N gives pwm=1 and frame_start=1 after edge N.
- Frame period is exactly PERIOD_US cycles, rising edge to rising edge, while enable stays 1.
- pwm high time is exactly active_length_us cycles, with no jitter.
- pwm and frame_start come directly from flops, with no combinational path from any input.
- active_length_us changes only on the frame-start edge and is stable for the whole frame.
- If enable and pulse_length_us both change on the frame-end edge, the new frame uses the values sampled on that edge.

## Test plan
- Reset then enable=1, pulse_length_us=1500, PERIOD_US=20000 -> pwm high 1500 cycles, low 18500 cycles, repeating; frame_start once per 20000 cycles; active_length_us=1500.
- pulse_length_us=0, then 65535, then `MIN_PWM_TIME_HIGH_US` (1000), then `MAX_PWM_TIME_HIGH_US` (2000) -> high times 1000, 2000, 1000, 2000 cycles.
- Change pulse_length_us 1200→1800 at cycle 600 of a 1200-cycle pulse -> current pulse stays 1200 cycles; next frame is 1800 cycles; active_length_us changes only at the next frame_start.
- Deassert enable 100 cycles into a pulse -> pulse completes its full length, frame completes all 20000 cycles, then pwm stays 0 in IDLE; re-enable -> pwm high on the next edge.
- Assert reset 700 cycles into a 1500-cycle pulse -> pwm 0 immediately, without a clock edge; active_length_us=1500 (DEFAULT); after release with enable=1, a fresh full frame starts.
- Loopback into the PWM reader with commanded lengths 1000, 1500, 2000 -> reader output matches each within ±2 µs after the second frame.
